axi_lite_arbiter: RTL and testbench

// - 2-master -> 1-slave AXI4-Lite arbiter; shares the single downstream port (xbar input)

---
 rtl/axi_lite_arbiter_if.sv | 39 +++
 rtl/axi_lite_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite channel bundle shared by the arbiter's upstream and downstream ports.
// 32-bit address/data, 4-bit write byte mask, 2-bit response codes.
interface axi_lite_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  // Transaction initiator side
  modport master (
    output araddr, arvalid, input  arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input  awready,
    output wdata, wmask, wvalid, input  wready,
    input  bresp, bvalid, output bready
  );

  // Transaction responder side
  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input  rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wmask, wvalid, output wready,
    output bresp, bvalid, input  bready
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// 2-master -> 1-slave AXI4-Lite arbiter (m0 = IFU, m1 = LSU).
// One whole transaction (AR+R or AW+W+B) is granted at a time; arbitration
// takes one IDLE cycle. Every output is a pure function of the FSM state and
// the granted master, so an async reset zeroes all outputs immediately.
// Optional macro ARB_RR_EN: round-robin on ties (winner = ~last granted).
// Without it, HIGH_PRIO wins every tie.
module axi_lite_arbiter #(
  parameter logic HIGH_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  axi_lite_if.slave   m0,
  axi_lite_if.slave   m1,
  axi_lite_if.master  s
);

  typedef enum logic [1:0] {IDLE, RD, WR_AW_W, WR_B} state_t;

  state_t state, state_nxt;
  logic   gnt, gnt_nxt;
  logic   aw_done, aw_done_nxt;
  logic   w_done, w_done_nxt;
`ifdef ARB_RR_EN
  logic   last, last_nxt;
`endif

  // Requests seen at arbitration time
  logic req0, req1, win, win_ar;

  // Granted-master view of its outgoing request signals
  logic [31:0] g_araddr, g_awaddr, g_wdata;
  logic [3:0]  g_wmask;
  logic        g_arvalid, g_awvalid, g_wvalid, g_rready, g_bready;

  // Handshakes that advance the FSM
  logic rd_fire, aw_fire, w_fire, b_fire;

  // Per-master channel ownership (only true while that master holds the grant)
  logic rd_own0, rd_own1, wr_own0, wr_own1, b_own0, b_own1;

  assign req0 = m0.arvalid | m0.awvalid;
  assign req1 = m1.arvalid | m1.awvalid;

  // Winner selection: single requester always wins; ties by priority or RR
  always_comb begin
    win = HIGH_PRIO;
    if (req0 && req1) begin
`ifdef ARB_RR_EN
      win = ~last;
`else
      win = HIGH_PRIO;
`endif
    end else if (req1) begin
      win = 1'b1;
    end else if (req0) begin
      win = 1'b0;
    end
  end

  // Read beats write when the winner presents both
  assign win_ar = win ? m1.arvalid : m0.arvalid;

  // Mux the granted master's request side
  always_comb begin
    g_araddr  = gnt ? m1.araddr  : m0.araddr;
    g_arvalid = gnt ? m1.arvalid : m0.arvalid;
    g_rready  = gnt ? m1.rready  : m0.rready;
    g_awaddr  = gnt ? m1.awaddr  : m0.awaddr;
    g_awvalid = gnt ? m1.awvalid : m0.awvalid;
    g_wdata   = gnt ? m1.wdata   : m0.wdata;
    g_wmask   = gnt ? m1.wmask   : m0.wmask;
    g_wvalid  = gnt ? m1.wvalid  : m0.wvalid;
    g_bready  = gnt ? m1.bready  : m0.bready;
  end

  assign rd_fire = (state == RD)      & s.rvalid  & g_rready;
  assign aw_fire = (state == WR_AW_W) & g_awvalid & ~aw_done & s.awready;
  assign w_fire  = (state == WR_AW_W) & g_wvalid  & ~w_done  & s.wready;
  assign b_fire  = (state == WR_B)    & s.bvalid  & g_bready;

  assign rd_own0 = (state == RD)      & ~gnt;
  assign rd_own1 = (state == RD)      &  gnt;
  assign wr_own0 = (state == WR_AW_W) & ~gnt;
  assign wr_own1 = (state == WR_AW_W) &  gnt;
  assign b_own0  = (state == WR_B)    & ~gnt;
  assign b_own1  = (state == WR_B)    &  gnt;

  // State, grant and write-progress registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= HIGH_PRIO;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
`ifdef ARB_RR_EN
      last    <= ~HIGH_PRIO;
`endif
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
`ifdef ARB_RR_EN
      last    <= last_nxt;
`endif
    end
  end

  // Next-state logic: arbitrate in IDLE, leave a transaction on its final response
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
`ifdef ARB_RR_EN
    last_nxt    = last;
`endif
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          gnt_nxt   = win;
          state_nxt = win_ar ? RD : WR_AW_W;
        end
      end
      RD: begin
        if (rd_fire) begin
          state_nxt = IDLE;
`ifdef ARB_RR_EN
          last_nxt  = gnt;
`endif
        end
      end
      WR_AW_W: begin
        // AW and W may land in either order or together
        aw_done_nxt = aw_done | aw_fire;
        w_done_nxt  = w_done  | w_fire;
        if (aw_done_nxt && w_done_nxt) state_nxt = WR_B;
      end
      WR_B: begin
        if (b_fire) begin
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          state_nxt   = IDLE;
`ifdef ARB_RR_EN
          last_nxt    = gnt;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Downstream port: only the active channel of the granted master is forwarded
  always_comb begin
    s.araddr  = '0;
    s.arvalid = 1'b0;
    s.rready  = 1'b0;
    s.awaddr  = '0;
    s.awvalid = 1'b0;
    s.wdata   = '0;
    s.wmask   = '0;
    s.wvalid  = 1'b0;
    s.bready  = 1'b0;
    case (state)
      RD: begin
        s.araddr  = g_araddr;
        s.arvalid = g_arvalid;
        s.rready  = g_rready;
      end
      WR_AW_W: begin
        // Completed halves are masked so the slave never sees a duplicate
        s.awaddr  = g_awaddr;
        s.awvalid = g_awvalid & ~aw_done;
        s.wdata   = g_wdata;
        s.wmask   = g_wmask;
        s.wvalid  = g_wvalid & ~w_done;
      end
      WR_B: s.bready = g_bready;
      default: ;
    endcase
  end

  // Upstream port m0: readies/responses only while m0 owns the channel
  always_comb begin
    m0.arready = rd_own0 & s.arready;
    m0.rvalid  = rd_own0 & s.rvalid;
    m0.rdata   = rd_own0 ? s.rdata : '0;
    m0.rresp   = rd_own0 ? s.rresp : '0;
    m0.awready = wr_own0 & s.awready & ~aw_done;
    m0.wready  = wr_own0 & s.wready  & ~w_done;
    m0.bvalid  = b_own0 & s.bvalid;
    m0.bresp   = b_own0 ? s.bresp : '0;
  end

  // Upstream port m1: readies/responses only while m1 owns the channel
  always_comb begin
    m1.arready = rd_own1 & s.arready;
    m1.rvalid  = rd_own1 & s.rvalid;
    m1.rdata   = rd_own1 ? s.rdata : '0;
    m1.rresp   = rd_own1 ? s.rresp : '0;
    m1.awready = wr_own1 & s.awready & ~aw_done;
    m1.wready  = wr_own1 & s.wready  & ~w_done;
    m1.bvalid  = b_own1 & s.bvalid;
    m1.bresp   = b_own1 ? s.bresp : '0;
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: reads, writes, contention, read+write
// on one master, async reset in WR_B, same-cycle AW/W acceptance.
module tb_axi_lite_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi_lite_if im0();
  axi_lite_if im1();
  axi_lite_if is();

  axi_lite_arbiter #(.HIGH_PRIO(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (im0),
    .m1    (im1),
    .s     (is)
  );

  int n_cmp = 0;
  int n_err = 0;
  int aw_hs = 0;
  int w_hs  = 0;
  int a0, w0;
  logic exp_g;

  // Every control output of the DUT, and an OR of all its data/resp outputs
  logic [20:0] ctl_outs;
  logic [31:0] dat_outs;
  assign ctl_outs = {is.arvalid, is.awvalid, is.wvalid, is.rready, is.bready,
                     im0.arready, im0.awready, im0.wready, im0.rvalid, im0.bvalid,
                     im1.arready, im1.awready, im1.wready, im1.rvalid, im1.bvalid,
                     im0.rresp, im0.bresp, im1.rresp[0]};
  assign dat_outs = is.araddr | is.awaddr | is.wdata | im0.rdata | im1.rdata |
                    {28'd0, is.wmask} | {30'd0, im1.rresp | im1.bresp};

  // Count downstream handshakes mid-cycle, where all signals are settled
  always @(negedge clk) begin
    if (!reset && is.awvalid && is.awready) aw_hs++;
    if (!reset && is.wvalid && is.wready) w_hs++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    im0.araddr = '0; im0.arvalid = 0; im0.rready = 0; im0.awaddr = '0; im0.awvalid = 0;
    im0.wdata = '0; im0.wmask = '0; im0.wvalid = 0; im0.bready = 0;
    im1.araddr = '0; im1.arvalid = 0; im1.rready = 0; im1.awaddr = '0; im1.awvalid = 0;
    im1.wdata = '0; im1.wmask = '0; im1.wvalid = 0; im1.bready = 0;
    is.arready = 0; is.rdata = '0; is.rresp = '0; is.rvalid = 0; is.awready = 0;
    is.wready = 0; is.bresp = '0; is.bvalid = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #2;
    chk("rst_ctl_outs", 32'(ctl_outs), 32'd0);
    chk("rst_dat_outs", dat_outs, 32'd0);
    step(); step();
    reset = 1'b0;

    // ---- single read on m0, data 3 cycles after AR request ----
    im0.araddr = 32'h8000_0000; im0.arvalid = 1; im0.rready = 1;
    smp();
    chk("t1_idle_s_arvalid", is.arvalid, 0);
    chk("t1_idle_m0_arready", im0.arready, 0);
    step(); is.arready = 1;
    smp();
    chk("t1_s_arvalid", is.arvalid, 1);
    chk("t1_s_araddr", is.araddr, 32'h8000_0000);
    chk("t1_m0_arready", im0.arready, 1);
    chk("t1_m1_arready", im1.arready, 0);
    step(); im0.arvalid = 0; is.arready = 0;
    for (int k = 0; k < 2; k++) begin
      smp(); chk("t1_wait_m0_rvalid", im0.rvalid, 0);
      step();
    end
    is.rvalid = 1; is.rdata = 32'hDEAD_BEEF;
    smp();
    chk("t1_m0_rvalid", im0.rvalid, 1);
    chk("t1_m0_rdata", im0.rdata, 32'hDEAD_BEEF);
    chk("t1_m1_rvalid", im1.rvalid, 0);
    chk("t1_s_rready", is.rready, 1);
    step();
    // back in IDLE; a stray rvalid must not reach anyone
    smp();
    chk("t1_idle_rvalid_ignored", {im1.rvalid, im0.rvalid}, 0);
    chk("t1_idle_s_rready", is.rready, 0);
    step(); is.rvalid = 0; is.rdata = '0; im0.rready = 0;

    // ---- write on m1, slave takes W two cycles before AW ----
    a0 = aw_hs; w0 = w_hs;
    im1.awaddr = 32'hA000_03F8; im1.awvalid = 1;
    im1.wdata = 32'h41; im1.wmask = 4'h1; im1.wvalid = 1; im1.bready = 1;
    smp();
    chk("t2_idle_s_valids", {is.awvalid, is.wvalid}, 0);
    step(); is.wready = 1;
    smp();
    chk("t2_s_wvalid", is.wvalid, 1);
    chk("t2_s_wdata", is.wdata, 32'h41);
    chk("t2_s_wmask", is.wmask, 4'h1);
    chk("t2_s_awvalid", is.awvalid, 1);
    chk("t2_m1_wready_awready", {im1.wready, im1.awready}, 2'b10);
    chk("t2_m0_wready", im0.wready, 0);
    step(); im1.wvalid = 0; is.wready = 0;
    smp();
    chk("t2_w_done_s_wvalid", is.wvalid, 0);
    chk("t2_aw_pending", {is.awvalid, im1.awready}, 2'b10);
    step(); is.awready = 1;
    smp();
    chk("t2_s_awaddr", is.awaddr, 32'hA000_03F8);
    chk("t2_m1_awready", im1.awready, 1);
    step(); im1.awvalid = 0; is.awready = 0;
    smp();
    chk("t2_wrb_s_bready", is.bready, 1);
    chk("t2_wrb_m1_bvalid", im1.bvalid, 0);
    chk("t2_wrb_s_awvalid", is.awvalid, 0);
    step(); is.bvalid = 1;
    smp();
    chk("t2_m1_bvalid", im1.bvalid, 1);
    chk("t2_m0_bvalid", im0.bvalid, 0);
    step(); is.bvalid = 0; im1.bready = 0;
    smp();
    chk("t2_idle_s_bready", is.bready, 0);
    chk("t2_aw_hs_count", aw_hs - a0, 1);
    chk("t2_w_hs_count", w_hs - w0, 1);

    // ---- reset so round-robin starts from HIGH_PRIO ----
    step(); reset = 1;
    step(); reset = 0;

    // ---- both masters request continuously, 6 reads ----
    im0.araddr = 32'h1000; im1.araddr = 32'h2000;
    im0.arvalid = 1; im1.arvalid = 1; im0.rready = 1; im1.rready = 1;
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_RR_EN
      exp_g = (i % 2 == 0);
`else
      exp_g = 1'b1;
`endif
      step(); is.arready = 1;
      smp();
      chk("t3_s_araddr", is.araddr, exp_g ? 32'h2000 : 32'h1000);
      step(); is.arready = 0; is.rvalid = 1; is.rdata = 32'(i);
      smp();
      chk("t3_grant", {im1.rvalid, im0.rvalid}, exp_g ? 2'b10 : 2'b01);
      step(); is.rvalid = 0;
    end
    im0.arvalid = 0; im1.arvalid = 0; im0.rready = 0; im1.rready = 0;

    // ---- m0 read and write together: read first, then write ----
    im0.araddr = 32'h3000; im0.arvalid = 1; im0.rready = 1;
    im0.awaddr = 32'h4000; im0.awvalid = 1;
    im0.wdata = 32'h55AA; im0.wmask = 4'hF; im0.wvalid = 1; im0.bready = 1;
    smp();
    chk("t4_idle_s_valids", {is.arvalid, is.awvalid, is.wvalid}, 0);
    step(); is.arready = 1;
    smp();
    chk("t4_rd_only", {is.arvalid, is.awvalid, is.wvalid}, 3'b100);
    step(); im0.arvalid = 0; is.arready = 0; is.rvalid = 1; is.rdata = 32'h1234;
    smp();
    chk("t4_m0_rvalid", im0.rvalid, 1);
    chk("t4_no_wr_overlap", {is.awvalid, is.wvalid}, 0);
    step(); is.rvalid = 0;
    smp();
    chk("t4_idle_between", {is.arvalid, is.awvalid, is.wvalid, is.rready}, 0);
    a0 = aw_hs; w0 = w_hs;
    step(); is.awready = 1; is.wready = 1;
    smp();
    chk("t4_wr_valids", {is.arvalid, is.awvalid, is.wvalid}, 3'b011);
    chk("t4_m0_readies", {im0.awready, im0.wready}, 2'b11);
    chk("t4_s_awaddr", is.awaddr, 32'h4000);
    chk("t4_s_wdata", is.wdata, 32'h55AA);
    // same-cycle AW+W: next cycle must be WR_B with no repeats
    step(); im0.awvalid = 0; im0.wvalid = 0; is.bvalid = 1; is.bresp = 2'b10;
    smp();
    chk("t6_wrb_s_bready", is.bready, 1);
    chk("t6_no_dup_valids", {is.awvalid, is.wvalid}, 0);
    chk("t6_no_readies", {im0.awready, im0.wready}, 0);
    chk("t6_aw_hs_count", aw_hs - a0, 1);
    chk("t6_w_hs_count", w_hs - w0, 1);
    chk("t6_m0_bvalid", im0.bvalid, 1);
    chk("t6_m0_bresp", im0.bresp, 2'b10);

    // ---- async reset while in WR_B, away from any clock edge ----
    #2 reset = 1;
    #1;
    chk("t5_async_ctl_outs", 32'(ctl_outs), 32'd0);
    chk("t5_async_dat_outs", dat_outs, 32'd0);
    idle_inputs();
    #1 reset = 0;
    step();
    im1.araddr = 32'h5000; im1.arvalid = 1; im1.rready = 1;
    smp();
    chk("t5_idle_after_rst", is.arvalid, 0);
    step(); is.arready = 1;
    smp();
    chk("t5_s_arvalid", is.arvalid, 1);
    chk("t5_s_araddr", is.araddr, 32'h5000);
    chk("t5_readies", {im1.arready, im0.arready}, 2'b10);
    step(); im1.arvalid = 0; is.arready = 0; is.rvalid = 1; is.rdata = 32'hCAFE;
    smp();
    chk("t5_m1_rdata", im1.rdata, 32'hCAFE);
    chk("t5_m0_rvalid", im0.rvalid, 0);
    step(); is.rvalid = 0; im1.rready = 0;
    smp();
    chk("t5_final_idle", 32'(ctl_outs), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
